// File: rtl/canvas_dump.sv
// Scans the stored canvas in raster order, packs two 4-bit pixels per byte and
// streams them out behind a fixed two-byte header on a valid/ready byte port.
module canvas_dump #(
  parameter int H_PIXELS     = 640,
  parameter int V_PIXELS     = 360,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                   pixel_clk_in,
  input  logic                                   rst_n_in,
  input  logic                                   start_in,
  input  logic                                   abort_in,
  output logic [$clog2(H_PIXELS*V_PIXELS)-1:0]   rd_addr_out,
  output logic                                   rd_en_out,
  input  logic [3:0]                             rd_data_in,
  output logic [7:0]                             data_out,
  output logic                                   valid_out,
  input  logic                                   ready_in,
  output logic                                   busy_out,
  output logic                                   done_out
);
  localparam int TOTAL  = H_PIXELS * V_PIXELS;
  localparam int ADDR_W = $clog2(TOTAL);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W  = $clog2(READ_LATENCY + 1);
  localparam int CRD_W  = $clog2(2 * FIFO_DEPTH + READ_LATENCY + 2) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, STREAM, DRAIN} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0]       addr;
  logic                    all_issued;
  logic [READ_LATENCY-1:0] rd_vld_p;
  logic [INF_W-1:0]        inflight;
  logic                    held;
  logic [3:0]              low_nib;
  logic [7:0]              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [OCC_W-1:0]        occ;
  logic                    done;

  logic active, issue, ret, push, pop, fifo_empty, stream_phase, finish, flush;
  logic [CRD_W-1:0] credit;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Every pixel slot (in flight, held nibble, half of a queued byte) is counted,
  // so a returning pixel always has room and the BRAM never needs a stall.
  assign credit       = (CRD_W'(occ) << 1) + CRD_W'(inflight) + CRD_W'(held);
  assign active       = (state != IDLE);
  assign fifo_empty   = (occ == '0);
  assign stream_phase = (state == STREAM) || (state == DRAIN);
  assign issue        = ((state == HDR0) || (state == HDR1) || (state == STREAM)) &&
                        !all_issued && !abort_in && (credit < CRD_W'(2 * FIFO_DEPTH));
  assign ret          = rd_vld_p[READ_LATENCY-1];
  assign push         = ret && held;
  assign pop          = stream_phase && !fifo_empty && ready_in;
  assign finish       = pop && all_issued && (occ == OCC_W'(1)) && (inflight == '0) && !held;
  assign flush        = (abort_in && active) || (!active && start_in) || finish;

  assign rd_addr_out = addr;
  assign rd_en_out   = issue;
  assign done_out    = done;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    valid_out  = 1'b0;
    data_out   = 8'h00;
    busy_out   = active;
    case (state)
      IDLE:   if (start_in) state_next = HDR0;
      HDR0: begin
        valid_out = 1'b1;
        data_out  = 8'hA5;
        if (ready_in) state_next = HDR1;
      end
      HDR1: begin
        valid_out = 1'b1;
        data_out  = 8'h5A;
        if (ready_in) state_next = STREAM;
      end
      STREAM, DRAIN: begin
        valid_out = !fifo_empty;
        data_out  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
        if (state == STREAM && all_issued) state_next = DRAIN;
      end
      default: state_next = IDLE;
    endcase
    if (finish) state_next = IDLE;
    if (abort_in && active) state_next = IDLE;
  end

  // p0: read issue and return tracking, FIFO control
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr       <= '0;
      all_issued <= 1'b0;
      rd_vld_p   <= '0;
      inflight   <= '0;
      held       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      done       <= 1'b0;
    end else begin
      done <= finish && !abort_in;
      if (flush) begin
        addr       <= '0;
        all_issued <= 1'b0;
        rd_vld_p   <= '0;
        inflight   <= '0;
        held       <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        occ        <= '0;
      end else begin
        rd_vld_p <= (rd_vld_p << 1) | READ_LATENCY'(issue);
        if (issue) begin
          addr       <= (addr == LAST_ADDR) ? addr : addr + ADDR_W'(1);
          all_issued <= (addr == LAST_ADDR);
        end
        inflight <= inflight + INF_W'(issue) - INF_W'(ret);
        if (ret)  held   <= !held;
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
    end
  end

  // p1: nibble packing into the byte FIFO
  always_ff @(posedge pixel_clk_in) begin
    if (ret && !held) low_nib <= rd_data_in;
    if (push) fifo_mem[wr_ptr] <= {rd_data_in, low_nib};
  end

endmodule

// File: tb/tb_canvas_dump.sv
// Directed bench for canvas_dump on a reduced 16x6 canvas with a pixel = addr[3:0]
// memory model.
module tb_canvas_dump;
  localparam int H = 16, V = 6, L = 2, D = 4;
  localparam int NPIX = H * V, NBYTES = 2 + NPIX / 2, AW = $clog2(NPIX);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic rd_en, valid, busy, done;
  logic [3:0] rd_data;
  logic [7:0] data;

  always #5 clk = ~clk;

  canvas_dump #(.H_PIXELS(H), .V_PIXELS(V), .READ_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .start_in(start), .abort_in(abort),
    .rd_addr_out(rd_addr), .rd_en_out(rd_en), .rd_data_in(rd_data),
    .data_out(data), .valid_out(valid), .ready_in(ready),
    .busy_out(busy), .done_out(done));

  // Memory model: pixel = addr[3:0], returned L cycles after the strobe; junk otherwise.
  logic [L-1:0] pipe_en = '0;
  logic [3:0]   pipe_pix [L];
  logic [3:0]   junk = 4'h0;
  always @(posedge clk) begin
    pipe_en     <= {pipe_en[L-2:0], rd_en};
    pipe_pix[0] <= rd_addr[3:0];
    pipe_pix[1] <= pipe_pix[0];
    junk        <= 4'($urandom);
  end
  assign rd_data = pipe_en[L-1] ? pipe_pix[L-1] : junk;

  int tests = 0, failed = 0;
  logic [7:0] got[$];
  int hs_cyc[$];
  int read_cnt[NPIX];
  int done_cnt, done_cyc, max_addr, first_addr, stab_err;

  typedef struct {
    logic st, ab, rdy;
    logic exp_valid;
    logic [7:0] exp_data;
    logic exp_busy, exp_done;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    int k;
    if (i == 0) return 8'hA5;
    if (i == 1) return 8'h5A;
    k = i - 2;
    return {4'((2 * k + 1) % 16), 4'((2 * k) % 16)};
  endfunction

  // mode 0: ready always high, mode 1: ready high 30% of cycles
  task automatic run_dump(input int mode, input int start_at, input int abort_at, input int rst_at);
    int cyc;
    bit fin, pend;
    logic [7:0] pdata;
    got.delete(); hs_cyc.delete();
    foreach (read_cnt[i]) read_cnt[i] = 0;
    done_cnt = 0; done_cyc = -1; max_addr = 0; first_addr = -1; stab_err = 0;
    cyc = 0; fin = 0; pend = 0; pdata = 8'h00;
    while (!fin && cyc < 2000) begin
      @(posedge clk); #1;
      start = (cyc == 0) || (cyc == start_at);
      abort = 1'b0;
      ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      if (abort_at > 0 && got.size() >= abort_at) begin
        abort = 1'b1;
        ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        repeat (4) begin
          @(negedge clk);
          if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        fin = 1;
      end else if (rst_at > 0 && got.size() >= rst_at && valid) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_data", data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_rd_addr", rd_addr, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        fin = 1;
      end else begin
        @(negedge clk);
        if (rd_en) begin
          if (rd_addr < NPIX) read_cnt[rd_addr]++;
          if (first_addr < 0) first_addr = rd_addr;
          if (int'(rd_addr) > max_addr) max_addr = rd_addr;
        end
        if (pend && (valid !== 1'b1 || data !== pdata)) stab_err++;
        pend  = valid && !ready;
        pdata = data;
        if (valid && ready) begin
          got.push_back(data);
          hs_cyc.push_back(cyc);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          fin = 1;
        end
      end
      cyc++;
    end
    start = 1'b0; ready = 1'b0; abort = 1'b0;
    if (!fin) begin
      tests++; failed++;
      $display("FAIL dump_timeout: got no completion, required one within 2000 cycles");
    end else if (abort_at == 0 && rst_at == 0) begin
      repeat (3) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
    end
  endtask

  task automatic check_stream(input string p);
    int bad_idx, bad_rd;
    bad_idx = -1;
    chk({p, "_len"}, got.size(), NBYTES);
    foreach (got[i]) if (bad_idx < 0 && got[i] !== exp_byte(i)) bad_idx = i;
    chk({p, "_first_bad_byte_idx"}, bad_idx, 32'hFFFF_FFFF);
    chk({p, "_last_byte"}, (got.size() > 0) ? got[got.size() - 1] : 8'h00, 8'hFE);
    chk({p, "_done_pulses"}, done_cnt, 1);
    chk({p, "_max_addr"}, max_addr, NPIX - 1);
    chk({p, "_first_addr"}, first_addr, 0);
    bad_rd = 0;
    foreach (read_cnt[i]) if (read_cnt[i] != 1) bad_rd++;
    chk({p, "_addrs_not_read_once"}, bad_rd, 0);
  endtask

  initial begin
    int gap_bad, lat;
    // start, abort, ready | valid, data, busy, done
    vecs[0]  = '{0, 0, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 8'hA5, 1, 0};
    vecs[3]  = '{0, 0, 0, 1, 8'hA5, 1, 0};
    vecs[4]  = '{1, 0, 1, 1, 8'hA5, 1, 0};
    vecs[5]  = '{0, 0, 0, 1, 8'h5A, 1, 0};
    vecs[6]  = '{0, 0, 1, 1, 8'h5A, 1, 0};
    vecs[7]  = '{0, 0, 0, 1, 8'h10, 1, 0};
    vecs[8]  = '{0, 0, 1, 1, 8'h10, 1, 0};
    vecs[9]  = '{0, 0, 1, 1, 8'h32, 1, 0};
    vecs[10] = '{0, 1, 0, 1, 8'h54, 1, 0};
    vecs[11] = '{0, 0, 1, 0, 8'h00, 0, 0};
    vecs[12] = '{1, 0, 1, 0, 8'h00, 0, 0};
    vecs[13] = '{0, 0, 1, 1, 8'hA5, 1, 0};
    vecs[14] = '{0, 0, 1, 1, 8'h5A, 1, 0};
    vecs[15] = '{0, 0, 1, 0, 8'h00, 1, 0};
    vecs[16] = '{0, 0, 1, 0, 8'h00, 1, 0};
    vecs[17] = '{0, 0, 0, 1, 8'h10, 1, 0};
    vecs[18] = '{0, 1, 0, 1, 8'h10, 1, 0};
    vecs[19] = '{0, 0, 0, 0, 8'h00, 0, 0};

    repeat (6) begin
      @(posedge clk); #1;
      start = 1'($urandom); abort = 1'($urandom); ready = 1'($urandom);
    end
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_valid", valid, 0);
    chk("post_rst_rd_en", rd_en, 0);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = vecs[i].st; abort = vecs[i].ab; ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);

    run_dump(0, -1, 0, 0);
    check_stream("full");
    chk("full_cycles_in_budget", done_cyc <= 2 * (NPIX / 2) + 16, 1);
    gap_bad = 0;
    for (int i = 3; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i - 1] != 2) gap_bad++;
    chk("full_stream_gaps_not_2", gap_bad, 0);
    lat = (hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[1] : 999;
    chk("full_first_byte_latency_ok", lat <= L + 3, 1);

    run_dump(1, -1, 0, 0);
    check_stream("bp");
    chk("bp_unstable_data", stab_err, 0);

    run_dump(0, 30, 0, 0);
    check_stream("start_mid");

    run_dump(0, -1, 20, 0);
    run_dump(0, -1, 0, 0);
    check_stream("after_abort");

    run_dump(1, -1, 0, 10);
    run_dump(1, -1, 0, 0);
    check_stream("after_arst");
    chk("after_arst_unstable_data", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
